// File: rtl/pc_ras_gen.sv
// Fetch program-counter generator with redirect priority and an optional
// circular return-address stack (enabled by defining PC_RAS_EN).
module pc_ras_gen #(
   parameter int               WIDTH     = 25,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] INC       = WIDTH'(1),
   parameter int               RAS_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             n_stall,
   input  logic             br_en,
   input  logic [WIDTH-1:0] br_pc,
   input  logic             call_en,
   input  logic [WIDTH-1:0] call_ret_pc,
   input  logic             ret_en,
   output logic [WIDTH-1:0] pc,
   output logic             ras_empty,
   output logic             ras_ovf
);

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;

   assign pc = pc_reg;

`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    ptr_reg, ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             empty_reg;
   logic             ovf_reg, ovf_next;
   logic             wr_en;
   logic [PW-1:0]    wr_addr;
   logic             do_pop;
   logic [WIDTH-1:0] ras_top;

   assign ras_top   = ras_mem[ptr_reg];
   assign do_pop    = ret_en && (count_reg != '0);
   assign ras_empty = empty_reg;
   assign ras_ovf   = ovf_reg;

   always_comb begin
      pc_next    = pc_reg;
      ptr_next   = ptr_reg;
      count_next = count_reg;
      ovf_next   = ovf_reg;
      wr_en      = 1'b0;
      wr_addr    = ptr_reg;
      if (br_en) begin
         // A redirect flushes fetch; decode hints in the same cycle are stale.
         pc_next = br_pc;
      end else if (n_stall) begin
         if (do_pop && call_en) begin
            // Return-then-call: swap the top entry in place.
            pc_next = ras_top;
            wr_en   = 1'b1;
         end else if (do_pop) begin
            pc_next    = ras_top;
            ptr_next   = ptr_reg - 1'b1;
            count_next = count_reg - 1'b1;
         end else begin
            pc_next = pc_reg + INC;
            if (call_en) begin
               ptr_next = ptr_reg + 1'b1;
               wr_en    = 1'b1;
               wr_addr  = ptr_reg + 1'b1;
               if (count_reg == CW'(RAS_DEPTH))
                  ovf_next = 1'b1;
               else
                  count_next = count_reg + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_PC;
         ptr_reg   <= '0;
         count_reg <= '0;
         empty_reg <= 1'b1;
         ovf_reg   <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         ptr_reg   <= ptr_next;
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         ovf_reg   <= ovf_next;
      end
   end

   // Storage is not reset; the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && wr_en)
         ras_mem[wr_addr] <= call_ret_pc;
   end
`else
   logic unused_ras;
   assign unused_ras = &{1'b0, call_en, ret_en, call_ret_pc};
   assign ras_empty  = 1'b1;
   assign ras_ovf    = 1'b0;

   always_comb begin
      pc_next = pc_reg;
      if (br_en)
         pc_next = br_pc;
      else if (n_stall)
         pc_next = pc_reg + INC;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pc_reg <= RESET_PC;
      else
         pc_reg <= pc_next;
   end
`endif

endmodule

// File: tb/tb_pc_ras_gen.sv
// Directed bench for pc_ras_gen: a vector table for sequential/redirect
// behaviour plus hand sequences for the return-address stack.
module tb_pc_ras_gen;

   localparam int WIDTH = 25;

   logic             clk = 1'b0;
   logic             rst, n_stall, br_en, call_en, ret_en;
   logic [WIDTH-1:0] br_pc, call_ret_pc, pc;
   logic             ras_empty, ras_ovf;

   int total  = 0;
   int passed = 0;
   int txn    = 0;

   always #5 clk = ~clk;

   pc_ras_gen #(
      .WIDTH(WIDTH), .RESET_PC(25'h100), .INC(25'd1), .RAS_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .n_stall(n_stall), .br_en(br_en), .br_pc(br_pc),
      .call_en(call_en), .call_ret_pc(call_ret_pc), .ret_en(ret_en),
      .pc(pc), .ras_empty(ras_empty), .ras_ovf(ras_ovf)
   );

   typedef struct {
      logic             rst, n_stall, br_en;
      logic [WIDTH-1:0] br_pc;
      logic             call_en;
      logic [WIDTH-1:0] call_ret_pc;
      logic             ret_en;
      logic [WIDTH-1:0] exp_pc;
      logic             exp_empty, exp_ovf;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         passed++;
   endtask

   // Drive one cycle of inputs, let the edge pass, compare all outputs.
   task automatic step(input logic r, input logic ns, input logic br, input logic [WIDTH-1:0] bpc,
                       input logic ce, input logic [WIDTH-1:0] cpc, input logic re,
                       input logic [WIDTH-1:0] e_pc, input logic e_empty, input logic e_ovf);
      rst = r; n_stall = ns; br_en = br; br_pc = bpc;
      call_en = ce; call_ret_pc = cpc; ret_en = re;
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d: rst=%b ns=%b br=%b call=%b ret=%b -> pc=%h empty=%b ovf=%b",
               txn, r, ns, br, ce, re, pc, ras_empty, ras_ovf);
      chk($sformatf("pc@%0d", txn), 32'(pc), 32'(e_pc));
      chk($sformatf("empty@%0d", txn), 32'(ras_empty), 32'(e_empty));
      chk($sformatf("ovf@%0d", txn), 32'(ras_ovf), 32'(e_ovf));
   endtask

   task automatic push(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] e_pc, input logic e_ovf);
`ifdef PC_RAS_EN
      step(0, 1, 0, '0, 1, v, 0, e_pc, 1'b0, e_ovf);
`else
      step(0, 1, 0, '0, 1, v, 0, e_pc, 1'b1, 1'b0);
`endif
   endtask

   task automatic pop(input logic [WIDTH-1:0] e_pc, input logic e_empty, input logic e_ovf);
      step(0, 1, 0, '0, 0, '0, 1, e_pc, e_empty, e_ovf);
   endtask

   initial begin
      rst = 1'b1; n_stall = 1'b0; br_en = 1'b0; br_pc = '0;
      call_en = 1'b0; call_ret_pc = '0; ret_en = 1'b0;

      //           rst n_st br  br_pc        call crpc ret  exp_pc       emp ovf
      vecs[0]  = '{1, 1, 1, 25'h0000055, 0, 0, 0, 25'h0000100, 1, 0};
      vecs[1]  = '{0, 0, 0, 25'h0,       0, 0, 0, 25'h0000100, 1, 0};
      vecs[2]  = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h0000101, 1, 0};
      vecs[3]  = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h0000102, 1, 0};
      vecs[4]  = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h0000103, 1, 0};
      vecs[5]  = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h0000104, 1, 0};
      vecs[6]  = '{0, 0, 0, 25'h0,       0, 0, 0, 25'h0000104, 1, 0};
      vecs[7]  = '{0, 0, 0, 25'h0,       0, 0, 0, 25'h0000104, 1, 0};
      vecs[8]  = '{0, 1, 1, 25'h1FFFFFE, 0, 0, 0, 25'h1FFFFFE, 1, 0};
      vecs[9]  = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h1FFFFFF, 1, 0};
      vecs[10] = '{0, 1, 0, 25'h0,       0, 0, 0, 25'h0000000, 1, 0};
      vecs[11] = '{0, 0, 1, 25'h0000040, 0, 0, 0, 25'h0000040, 1, 0};
      vecs[12] = '{0, 0, 0, 25'h0,       1, 7, 1, 25'h0000040, 1, 0};
      vecs[13] = '{0, 1, 1, 25'h0000080, 1, 9, 1, 25'h0000080, 1, 0};
      vecs[14] = '{0, 0, 1, 25'h0000040, 0, 0, 0, 25'h0000040, 1, 0};
      vecs[15] = '{0, 1, 0, 25'h0,       0, 0, 1, 25'h0000041, 1, 0};

      @(posedge clk);
      for (int i = 0; i < 16; i++)
         step(vecs[i].rst, vecs[i].n_stall, vecs[i].br_en, vecs[i].br_pc, vecs[i].call_en,
              vecs[i].call_ret_pc, vecs[i].ret_en, vecs[i].exp_pc, vecs[i].exp_empty, vecs[i].exp_ovf);
      // pc = 0x41, stack empty

`ifdef PC_RAS_EN
      push(25'h11, 25'h42, 0);
      push(25'h22, 25'h43, 0);
      push(25'h33, 25'h44, 0);
      pop(25'h33, 0, 0);
      pop(25'h22, 0, 0);
      pop(25'h11, 1, 0);
      pop(25'h12, 1, 0);
      for (int i = 1; i <= 9; i++)
         push(WIDTH'(i), WIDTH'(25'h12 + i), (i == 9));
      for (int i = 9; i >= 2; i--)
         pop(WIDTH'(i), (i == 2), 1);
      pop(25'h3, 1, 1);
      push(25'h50, 25'h4, 1);
      step(0, 1, 1, 25'h200, 1, 25'h60, 1, 25'h200, 0, 1);
      step(0, 1, 0, 25'h0,   1, 25'h60, 1, 25'h50,  0, 1);
      pop(25'h60, 1, 1);
      step(0, 1, 0, 25'h0,   1, 25'h70, 1, 25'h61,  0, 1);
      pop(25'h70, 1, 1);
      push(25'h1, 25'h71, 1);
      push(25'h2, 25'h72, 1);
      push(25'h3, 25'h73, 1);
      step(1, 1, 1, 25'h300, 1, 25'h9, 1, 25'h100, 1, 0);
      pop(25'h101, 1, 0);
      push(25'hAA, 25'h102, 0);
      step(0, 0, 0, 25'h0, 0, 25'h0, 1, 25'h102, 0, 0);
      pop(25'hAA, 1, 0);
`else
      push(25'h11, 25'h42, 0);
      push(25'h22, 25'h43, 0);
      pop(25'h44, 1, 0);
      for (int i = 1; i <= 9; i++)
         push(WIDTH'(i), WIDTH'(25'h44 + i), 0);
      step(0, 1, 0, 25'h0, 1, 25'h60, 1, 25'h4E, 1, 0);
      pop(25'h4F, 1, 0);
      step(1, 1, 1, 25'h300, 1, 25'h9, 1, 25'h100, 1, 0);
      pop(25'h101, 1, 0);
      step(0, 0, 0, 25'h0, 0, 25'h0, 1, 25'h101, 1, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
